// File: rtl/wb4_fifo_reader_pkg.sv
// wb4_fifo_reader_pkg
//   Shared definitions for the WB4 FIFO reader: FSM state encodings and
//   the helper that sizes the buffer pointers and the outstanding counter.
//   There are no ports. It is imported by wb4_fifo_reader and
//   wb4_fifo_reader_buf.
package wb4_fifo_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } state_e;

  // The extra MSB separates the full condition from the empty condition,
  // and lets the outstanding counter hold the value DEPTH.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/wb4_fifo_reader_buf.sv
// wb4_fifo_reader_buf
//   Circular buffer with power-of-two depth. The read side is
//   first-word-fall-through: the head entry is presented combinationally,
//   so a word that is pushed becomes visible in the next cycle.
// Ports:
//   i_clk, i_rst     clock and asynchronous active-low reset
//   i_push           write i_push_data at the tail
//   i_push_data      data to write
//   i_pop            advance the head. This input is ignored while empty.
//   o_pop_data       head entry. It reads zero while the buffer is empty.
//   o_count          number of stored entries (0..P_BUF_DEPTH)
//   o_empty, o_full  occupancy flags
module wb4_fifo_reader_buf
  import wb4_fifo_reader_pkg::*;
#(
  parameter int P_DATA_MSB  = 7,
  parameter int P_BUF_DEPTH = 4,
  localparam int PW         = ptr_width(P_BUF_DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic [P_DATA_MSB:0] i_push_data,
  input  logic              i_pop,
  output logic [P_DATA_MSB:0] o_pop_data,
  output logic [PW-1:0]     o_count,
  output logic              o_empty,
  output logic              o_full
);

  localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

  logic [P_DATA_MSB:0] mem_q [P_BUF_DEPTH];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic                do_pop;

  assign o_empty = (wr_ptr_q == rd_ptr_q);
  assign o_full  = (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]) &&
                   (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]);
  // The pointers wrap modulo 2*DEPTH, so a plain subtraction gives the count.
  assign o_count = wr_ptr_q - rd_ptr_q;
  assign do_pop  = i_pop && !o_empty;

  // Mask the head while empty. The storage is not reset, so this keeps
  // stale or uninitialised contents off the output.
  assign o_pop_data = o_empty ? '0 : mem_q[rd_ptr_q[PW-2:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (i_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) mem_q[wr_ptr_q[PW-2:0]] <= i_push_data;
  end

endmodule

// File: rtl/wb4_fifo_reader.sv
// wb4_fifo_reader
//   Wishbone B4 pipelined read master that drains an upstream FIFO slave
//   into a valid/ready stream. The number of reads in flight is limited by
//   credit: outstanding reads plus buffered words never exceed
//   P_BUF_DEPTH, so every ack always has a free slot in the buffer.
// Ports:
//   i_clk, i_rst            clock and asynchronous active-low reset
//   i_enable                request draining of the FIFO
//   o_wb4_cyc, o_wb4_stb    WB4 cycle and strobe (read-only master)
//   i_wb4_stall, i_wb4_ack  WB4 slave stall and acknowledge
//   i_wb4_data              read data, qualified by ack
//   o_valid, i_ready,       output stream
//   o_data
//   o_err                   sticky flag, set by an ack with nothing outstanding
module wb4_fifo_reader
  import wb4_fifo_reader_pkg::*;
#(
  parameter int P_DATA_MSB  = 7,
  parameter int P_BUF_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_enable,
  output logic              o_wb4_cyc,
  output logic              o_wb4_stb,
  input  logic              i_wb4_stall,
  input  logic              i_wb4_ack,
  input  logic [P_DATA_MSB:0] i_wb4_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [P_DATA_MSB:0] o_data,
  output logic              o_err
);

  localparam int PW = ptr_width(P_BUF_DEPTH);
  localparam logic [PW-1:0] CNT_ONE = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW:0]   DEPTH_C = P_BUF_DEPTH[PW:0];

  state_e        state_q, state_d;
  logic [PW-1:0] outstanding_q, outstanding_d;
  logic          err_q, err_d;

  logic [PW-1:0] buf_count;
  logic          buf_empty;
  logic          buf_full;
  logic [PW:0]   credit_sum;
  logic          credit_ok;
  logic          accept;
  logic          ack_ok;
  logic          ack_bad;

  // One extra bit, so the sum cannot overflow before the compare.
  assign credit_sum = {1'b0, outstanding_q} + {1'b0, buf_count};
  assign credit_ok  = (credit_sum < DEPTH_C);

  // The strobe is built only from registered state, so it has no path
  // from stall, ack or ready.
  assign o_wb4_stb = (state_q == ST_ACTIVE) && credit_ok;
  assign o_wb4_cyc = (state_q != ST_IDLE);

  assign accept  = o_wb4_stb && !i_wb4_stall;
  assign ack_ok  = i_wb4_ack && (outstanding_q != '0);
  assign ack_bad = i_wb4_ack && (outstanding_q == '0);

  always_comb begin
    outstanding_d = outstanding_q;
    err_d         = err_q | ack_bad;
    unique case ({accept, ack_ok})
      2'b10:   outstanding_d = outstanding_q + CNT_ONE;
      2'b01:   outstanding_d = outstanding_q - CNT_ONE;
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (i_enable) state_d = ST_ACTIVE;
      ST_ACTIVE: if (!i_enable) state_d = ST_DRAIN;
      // Re-enable takes priority. Otherwise stay until every ack is in.
      ST_DRAIN: begin
        if (i_enable)                     state_d = ST_ACTIVE;
        else if (outstanding_q == '0)     state_d = ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q       <= ST_IDLE;
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
    end
  end

  assign o_err = err_q;

  wb4_fifo_reader_buf #(
    .P_DATA_MSB  (P_DATA_MSB),
    .P_BUF_DEPTH (P_BUF_DEPTH)
  ) u_buf (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (ack_ok),
    .i_push_data (i_wb4_data),
    .i_pop       (i_ready),
    .o_pop_data  (o_data),
    .o_count     (buf_count),
    .o_empty     (buf_empty),
    .o_full      (buf_full)
  );

  assign o_valid = !buf_empty;

  // The credit rule should make a push into a full buffer impossible.
  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst)
                                  !(ack_ok && buf_full));

endmodule
